// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 SCCB write master.
package ov5640_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    XBIT,
    STOP,
    GAP
  } sccb_state_e;

  // 4 quarters START + 4 bytes * 9 bits * 4 quarters + 4 quarters STOP
  localparam int         FRAME_QUARTERS = 152;
  localparam logic [7:0] DEV_ID_DEFAULT = 8'h78;

endpackage

// File: rtl/ov5640_sccb_wr_if.sv
// Write-request handshake between the register sequencer and the SCCB master.
interface ov5640_sccb_wr_if;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/ov5640_sccb_wr_qtick.sv
// Quarter-SCL-period tick generator: one tick every CLK_DIV cycles plus a
// free-running 2-bit quarter index. clr restarts both so a frame starts at q0.
module sccb_qtick #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // divider counter and quarter index, restarted on clr
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (tick) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ov5640_sccb_wr.sv
// SCCB 3-phase write master for the OV5640: ID, addr_hi, addr_lo, data.
// Write-only; the 9th (ACK) bit is released and never looked at.
module ov5640_sccb_wr
  import ov5640_pkg::*;
#(
  parameter int         CLK_DIV    = 50,
  parameter logic [7:0] DEV_ID     = DEV_ID_DEFAULT,
  parameter int         STOP_GAP_Q = 4
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              sccb_begin,
  ov5640_sccb_wr_if.slave   wr,
  output logic              busy,
  output logic              done,
  output logic              sioc,
  output logic              siod_out,
  output logic              siod_oe
);

  localparam int            GW       = (STOP_GAP_Q > 1) ? $clog2(STOP_GAP_Q) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((STOP_GAP_Q > 0) ? STOP_GAP_Q - 1 : 0);

  sccb_state_e   state, state_nxt;
  logic          begin_q;
  logic          accept;
  logic          tick;
  logic [1:0]    quarter;
  logic          phase_end;
  logic [31:0]   sh;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic          done_nxt;
  logic          sd_hold;
  logic          sd_val;
  logic          sioc_c;
  logic          oe_c;

  assign wr.wr_ready = begin_q && (state == IDLE);
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign phase_end   = tick && (quarter == 2'd3);
  assign busy        = (state != IDLE);
  assign sioc        = sioc_c;
  assign siod_oe     = oe_c;
  assign siod_out    = sd_val;

  sccb_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk     (sclk),
    .rst     (s_rst),
    .clr     (accept),
    .tick    (tick),
    .quarter (quarter)
  );

  // state, sticky begin latch, done pulse and last driven SIOD value
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state   <= IDLE;
      begin_q <= 1'b0;
      done    <= 1'b0;
      sd_hold <= 1'b1;
    end else begin
      state   <= state_nxt;
      begin_q <= begin_q | sccb_begin;
      done    <= done_nxt;
      sd_hold <= sd_val;
    end
  end

  // payload shifter, bit/byte position and stop-gap quarter count
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      sh       <= '0;
      bit_cnt  <= 3'd7;
      byte_cnt <= 2'd0;
      gap_cnt  <= '0;
    end else begin
      if (accept) begin
        sh       <= {DEV_ID, wr.wr_addr, wr.wr_data};
        bit_cnt  <= 3'd7;
        byte_cnt <= 2'd0;
      end else if (phase_end) begin
        // bit_cnt wraps 0 -> 7 on its own, ready for the next byte
        if (state == BIT) begin
          sh      <= {sh[30:0], 1'b0};
          bit_cnt <= bit_cnt - 3'd1;
        end
        if (state == XBIT) byte_cnt <= byte_cnt + 2'd1;
      end
      if (state != GAP)  gap_cnt <= '0;
      else if (tick)     gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // next state plus per-quarter SIOC/SIOD shaping
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    sioc_c    = 1'b1;
    oe_c      = 1'b0;
    sd_val    = sd_hold;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        // SIOD falls at q1 with SIOC still high
        oe_c   = 1'b1;
        sioc_c = (quarter != 2'd3);
        sd_val = (quarter == 2'd0);
        if (phase_end) state_nxt = BIT;
      end
      BIT: begin
        oe_c   = 1'b1;
        sioc_c = (quarter == 2'd1) || (quarter == 2'd2);
        sd_val = sh[31];
        if (phase_end && bit_cnt == 3'd0) state_nxt = XBIT;
      end
      XBIT: begin
        sioc_c = (quarter == 2'd1) || (quarter == 2'd2);
        if (phase_end) state_nxt = (byte_cnt == 2'd3) ? STOP : BIT;
      end
      STOP: begin
        // SIOD rises at q2 with SIOC already high
        oe_c   = 1'b1;
        sioc_c = (quarter != 2'd0);
        sd_val = quarter[1];
        if (phase_end) begin
          if (STOP_GAP_Q == 0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (tick && gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ov5640_sccb_wr.sv
// Directed bench: DUT a at CLK_DIV=50/STOP_GAP_Q=4, DUT b at CLK_DIV=2/STOP_GAP_Q=0.
module tb_ov5640_sccb_wr;

  logic       sclk = 1'b0;
  logic       s_rst;
  logic [1:0] bgn;
  logic [1:0] busy_w, done_w, sioc_w, sd_w, oe_w;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  ov5640_sccb_wr_if ifa ();
  ov5640_sccb_wr_if ifb ();

  ov5640_sccb_wr #(.CLK_DIV(50), .DEV_ID(8'h78), .STOP_GAP_Q(4)) dut_a (
    .sclk(sclk), .s_rst(s_rst), .sccb_begin(bgn[0]), .wr(ifa),
    .busy(busy_w[0]), .done(done_w[0]), .sioc(sioc_w[0]),
    .siod_out(sd_w[0]), .siod_oe(oe_w[0])
  );

  ov5640_sccb_wr #(.CLK_DIV(2), .DEV_ID(8'h78), .STOP_GAP_Q(0)) dut_b (
    .sclk(sclk), .s_rst(s_rst), .sccb_begin(bgn[1]), .wr(ifb),
    .busy(busy_w[1]), .done(done_w[1]), .sioc(sioc_w[1]),
    .siod_out(sd_w[1]), .siod_oe(oe_w[1])
  );

  function automatic logic rdy(input int d);
    return (d == 0) ? ifa.wr_ready : ifb.wr_ready;
  endfunction

  function automatic logic vld(input int d);
    return (d == 0) ? ifa.wr_valid : ifb.wr_valid;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // bus monitor: START/STOP edges, data bits on SIOC rise, 9th-bit release
  int          start_n [2];
  int          stop_n  [2];
  int          xoe_bad [2];
  int          nrise   [2];
  logic        armed   [2];
  logic        p_sioc  [2];
  logic        p_sd    [2];
  logic [31:0] word    [2];
  logic [31:0] cap     [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_n[d] = 0; stop_n[d] = 0; xoe_bad[d] = 0; nrise[d] = 0;
      armed[d] = 1'b0; p_sioc[d] = 1'b1; p_sd[d] = 1'b1;
      word[d] = '0; cap[d] = '0;
    end
    forever begin
      @(negedge sclk);
      for (int d = 0; d < 2; d++) begin
        if (s_rst) begin
          armed[d] = 1'b0;
        end else begin
          if (p_sioc[d] && sioc_w[d] && oe_w[d] && p_sd[d] && !sd_w[d]) begin
            start_n[d]++;
            armed[d] = 1'b1;
            nrise[d] = 0;
          end else if (p_sioc[d] && sioc_w[d] && oe_w[d] && !p_sd[d] && sd_w[d]) begin
            stop_n[d]++;
          end
          if (!p_sioc[d] && sioc_w[d] && armed[d]) begin
            if (nrise[d] % 9 == 8) begin
              if (oe_w[d]) xoe_bad[d]++;
            end else begin
              word[d] = {word[d][30:0], sd_w[d]};
            end
            nrise[d]++;
            if (nrise[d] == 36) begin
              armed[d] = 1'b0;
              cap[d]   = word[d];
            end
          end
        end
        p_sioc[d] = sioc_w[d];
        p_sd[d]   = sd_w[d];
      end
    end
  end

  // wait for a handshake; ac is the cycle count right after the accepting edge
  task automatic accept(input int d, output int ac);
    int t;
    t = 0;
    while (!(rdy(d) && vld(d)) && t < 20000) begin
      @(negedge sclk);
      t++;
    end
    if (t >= 20000) begin
      chk("accept_timeout", 32'd0, 32'd1);
      ac = -1;
    end else begin
      ac = cyc + 1;
    end
    @(posedge sclk);
    #1;
  endtask

  // returns at the negedge inside the done cycle
  task automatic wait_done(input int d, output int dc);
    int t;
    t = 0;
    do begin
      @(negedge sclk);
      t++;
    end while (!done_w[d] && t < 20000);
    if (t >= 20000) chk("done_timeout", 32'd0, 32'd1);
    dc = cyc;
  endtask

  int a0, a1, a2, a3, a4, b0, d0, d1, d2, d4, bd;
  int hits, line_bad;

  initial begin
    s_rst = 1'b1;
    bgn   = 2'b00;
    ifa.wr_valid = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifb.wr_valid = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_ready", ifa.wr_ready, 1'b0);
    chk("rst_busy",  busy_w[0],   1'b0);
    chk("rst_done",  done_w[0],   1'b0);
    chk("rst_sioc",  sioc_w[0],   1'b1);
    chk("rst_siod",  sd_w[0],     1'b1);
    chk("rst_oe",    oe_w[0],     1'b0);
    @(posedge sclk); #1;
    s_rst = 1'b0;

    // request held off until begin is seen
    ifa.wr_valid = 1'b1; ifa.wr_addr = 16'h3008; ifa.wr_data = 8'h82;
    hits = 0; line_bad = 0;
    repeat (1000) begin
      @(negedge sclk);
      if (ifa.wr_ready) hits++;
      if (!sioc_w[0] || oe_w[0] || busy_w[0]) line_bad++;
    end
    chk("pre_begin_ready", hits, 0);
    chk("pre_begin_lines", line_bad, 0);

    // one-cycle begin pulse must stick
    @(posedge sclk); #1; bgn[0] = 1'b1;
    @(posedge sclk); #1; bgn[0] = 1'b0;
    accept(0, a0);
    ifa.wr_valid = 1'b0;
    @(negedge sclk);
    chk("busy_after_acc", busy_w[0], 1'b1);
    wait_done(0, d0);
    chk("lat_a", d0 - a0, 7800);
    chk("ready_at_done", ifa.wr_ready, 1'b1);
    chk("busy_at_done", busy_w[0], 1'b0);
    chk("bytes_3008", cap[0], 32'h78300882);
    chk("start_seen", start_n[0], 1);
    chk("stop_seen", stop_n[0], 1);
    chk("ack_released", xoe_bad[0], 0);
    @(negedge sclk);
    chk("done_width", done_w[0], 1'b0);

    // back-to-back with valid held high
    ifa.wr_valid = 1'b1; ifa.wr_addr = 16'h3103; ifa.wr_data = 8'h11;
    accept(0, a1);
    ifa.wr_addr = 16'h300e; ifa.wr_data = 8'h58;
    wait_done(0, d1);
    chk("b2b_lat1", d1 - a1, 7800);
    chk("b2b_acc_in_done", ifa.wr_ready && ifa.wr_valid, 1'b1);
    chk("bytes_3103", cap[0], 32'h78310311);
    accept(0, a2);
    ifa.wr_valid = 1'b0;
    chk("b2b_no_bubble", a2, d1 + 1);
    wait_done(0, d2);
    chk("b2b_lat2", d2 - a2, 7800);
    chk("bytes_300e", cap[0], 32'h78300e58);
    chk("ack_released_b2b", xoe_bad[0], 0);

    // reset in the middle of a frame
    ifa.wr_valid = 1'b1; ifa.wr_addr = 16'h3a3a; ifa.wr_data = 8'h5a;
    accept(0, a3);
    while (cyc < a3 + 3000) @(posedge sclk);
    #1; s_rst = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    chk("abort_sioc",  sioc_w[0],   1'b1);
    chk("abort_oe",    oe_w[0],     1'b0);
    chk("abort_busy",  busy_w[0],   1'b0);
    chk("abort_ready", ifa.wr_ready, 1'b0);
    chk("abort_siod",  sd_w[0],     1'b1);
    @(posedge sclk); #1; s_rst = 1'b0;
    hits = 0;
    repeat (200) begin
      @(negedge sclk);
      if (ifa.wr_ready || busy_w[0]) hits++;
    end
    chk("abort_begin_cleared", hits, 0);
    chk("abort_no_stop", stop_n[0], 3);
    @(posedge sclk); #1; bgn[0] = 1'b1;
    accept(0, a4);
    ifa.wr_valid = 1'b0;
    wait_done(0, d4);
    chk("post_abort_lat", d4 - a4, 7800);
    chk("bytes_3a3a", cap[0], 32'h783a3a5a);
    chk("start_total", start_n[0], 5);
    chk("stop_total", stop_n[0], 4);

    // fast divider, no stop gap
    @(posedge sclk); #1; bgn[1] = 1'b1;
    ifb.wr_valid = 1'b1; ifb.wr_addr = 16'h4300; ifb.wr_data = 8'h6f;
    accept(1, b0);
    ifb.wr_valid = 1'b0;
    wait_done(1, bd);
    chk("lat_b", bd - b0, 304);
    chk("bytes_b", cap[1], 32'h7843006f);
    chk("ack_released_b", xoe_bad[1], 0);
    chk("stop_b", stop_n[1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
